lcd_frame_sequencer: RTL and testbench

LCD_FRAME_SEQUENCER -- requirements
Module: lcd_frame_sequencer

---
 rtl/lcd_frame_sequencer.sv | 162 ++++++++++++++++
 tb/tb_lcd_frame_sequencer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_sequencer.sv
// Sequences the LCD init command, then per-row address/refresh pairs, with an
// inter-frame gap, freeze hold and wait-timeout recovery.
module lcd_frame_sequencer #(
  parameter int NUM_ROWS    = 2,
  parameter int TIMEOUT_CYC = 1000,
  parameter int GAP_CYC     = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic lcd_finish,
  input  logic freeze,
  output logic lcd_enable,
  output logic mode,
  output logic reg_sel,
  output logic DB_sel,
  output logic data_sel,
  output logic [((NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1)-1:0] row_addr,
  output logic frame_done,
  output logic timeout_err,
  output logic [7:0] err_cnt
);

  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int WW = $clog2(TIMEOUT_CYC);
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE,
    INIT_ISS,
    INIT_WAIT,
    ADDR_ISS,
    ADDR_WAIT,
    REF_ISS,
    REF_WAIT,
    GAP
  } state_t;

  state_t        state, state_n;
  logic [WW-1:0] wait_cnt, wait_n;
  logic [GW-1:0] gap_cnt, gap_n;
  logic [RW-1:0] row_n;
  logic [7:0]    err_n;
  logic          done_n, terr_n;
  logic          in_wait;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      row_addr    <= '0;
      err_cnt     <= '0;
      frame_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_n;
      gap_cnt     <= gap_n;
      row_addr    <= row_n;
      err_cnt     <= err_n;
      frame_done  <= done_n;
      timeout_err <= terr_n;
    end
  end

  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    gap_n   = gap_cnt;
    row_n   = row_addr;
    err_n   = err_cnt;
    done_n  = 1'b0;
    terr_n  = 1'b0;
    in_wait = (state == INIT_WAIT) || (state == ADDR_WAIT) || (state == REF_WAIT);

    case (state)
      IDLE:     state_n = INIT_ISS;
      INIT_ISS: begin
        state_n = INIT_WAIT;
        wait_n  = '0;
      end
      INIT_WAIT: if (lcd_finish) begin
        state_n = ADDR_ISS;
        row_n   = '0;
      end
      ADDR_ISS: begin
        state_n = ADDR_WAIT;
        wait_n  = '0;
      end
      ADDR_WAIT: if (lcd_finish) state_n = REF_ISS;
      REF_ISS: begin
        state_n = REF_WAIT;
        wait_n  = '0;
      end
      REF_WAIT: if (lcd_finish) begin
        if (row_addr == RW'(NUM_ROWS - 1)) begin
          done_n = 1'b1;
          row_n  = '0;
          if (GAP_CYC == 0) begin
            state_n = ADDR_ISS;
          end else begin
            state_n = GAP;
            gap_n   = '0;
          end
        end else begin
          row_n   = row_addr + RW'(1);
          state_n = ADDR_ISS;
        end
      end
      GAP: begin
        // At expiry the count is held, so freeze simply parks the FSM here.
        if (gap_cnt == GW'(GAP_CYC - 1)) begin
          if (!freeze) state_n = ADDR_ISS;
        end else begin
          gap_n = gap_cnt + GW'(1);
        end
      end
      default:  state_n = IDLE;
    endcase

    // lcd_finish on the final wait cycle takes precedence over the timeout.
    if (in_wait && !lcd_finish) begin
      if (wait_cnt == WW'(TIMEOUT_CYC - 1)) begin
        terr_n  = 1'b1;
        row_n   = '0;
        state_n = INIT_ISS;
        if (err_cnt != 8'hFF) err_n = err_cnt + 8'd1;
      end else begin
        wait_n = wait_cnt + WW'(1);
      end
    end
  end

  always_comb begin
    lcd_enable = 1'b0;
    mode       = 1'b1;
    reg_sel    = 1'b0;
    DB_sel     = 1'b1;
    data_sel   = 1'b0;
    case (state)
      INIT_ISS:  lcd_enable = 1'b1;
      ADDR_ISS: begin
        lcd_enable = 1'b1;
        DB_sel     = 1'b0;
      end
      ADDR_WAIT: DB_sel = 1'b0;
      REF_ISS: begin
        lcd_enable = 1'b1;
        mode       = 1'b0;
        reg_sel    = 1'b1;
        data_sel   = 1'b1;
      end
      REF_WAIT: begin
        mode     = 1'b0;
        reg_sel  = 1'b1;
        data_sel = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed bench: a default-parameter instance for sequencing, timeout, freeze
// and reset, plus a NUM_ROWS=1 / TIMEOUT_CYC=2 / GAP_CYC=0 instance.
module tb_lcd_frame_sequencer;

  localparam logic [3:0] CTL_INIT = 4'b1010;
  localparam logic [3:0] CTL_ADDR = 4'b1000;
  localparam logic [3:0] CTL_REF  = 4'b0111;
  localparam logic [6:0] RST_OUTS = 7'b0101000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic lcd_finish = 1'b0;
  logic freeze = 1'b0;
  logic lcd_enable, mode, reg_sel, DB_sel, data_sel, frame_done, timeout_err;
  logic [0:0] row_addr;
  logic [7:0] err_cnt;

  logic s_rst = 1'b1;
  logic s_finish = 1'b0;
  logic s_freeze = 1'b0;
  logic s_en, s_mode, s_reg_sel, s_DB_sel, s_data_sel, s_done, s_terr;
  logic [0:0] s_row;
  logic [7:0] s_err_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int en_cnt = 0, fd_cnt = 0, fd_last = -1, te_cnt = 0, te_last = -1;
  int s_fd_cnt = 0, s_te_cnt = 0, s_en_cnt = 0;
  logic s_row_bad = 1'b0;

  lcd_frame_sequencer dut (
    .clk(clk), .rst(rst), .lcd_finish(lcd_finish), .freeze(freeze),
    .lcd_enable(lcd_enable), .mode(mode), .reg_sel(reg_sel), .DB_sel(DB_sel),
    .data_sel(data_sel), .row_addr(row_addr), .frame_done(frame_done),
    .timeout_err(timeout_err), .err_cnt(err_cnt)
  );

  lcd_frame_sequencer #(.NUM_ROWS(1), .TIMEOUT_CYC(2), .GAP_CYC(0)) dut_small (
    .clk(clk), .rst(s_rst), .lcd_finish(s_finish), .freeze(s_freeze),
    .lcd_enable(s_en), .mode(s_mode), .reg_sel(s_reg_sel), .DB_sel(s_DB_sel),
    .data_sel(s_data_sel), .row_addr(s_row), .frame_done(s_done),
    .timeout_err(s_terr), .err_cnt(s_err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (lcd_enable) en_cnt++;
    if (frame_done) begin fd_cnt++; fd_last = cyc; end
    if (timeout_err) begin te_cnt++; te_last = cyc; end
    if (s_en) s_en_cnt++;
    if (s_done) s_fd_cnt++;
    if (s_terr) s_te_cnt++;
    if (!s_rst && s_row != 1'b0) s_row_bad = 1'b1;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, actual, actual, expected, expected);
    end
  endtask

  // Waits for the next lcd_enable pulse, capturing the cycle and the control decode.
  task automatic waitEnable(output int t, output logic [3:0] ctl, output logic [0:0] row);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lcd_enable && n < 1200);
    if (!lcd_enable) begin
      checkOutput("enable_wait_expired", 0, 1);
      t = -1;
    end else begin
      t = cyc;
    end
    ctl = {mode, reg_sel, DB_sel, data_sel};
    row = row_addr;
  endtask

  // Drives lcd_finish for exactly the given cycle.
  task automatic applyStimulus(input int target);
    while (cyc < target) @(negedge clk);
    lcd_finish = 1'b1;
    @(posedge clk);
    #1 lcd_finish = 1'b0;
  endtask

  initial begin
    int t, tr, ta, ti, tf, e0, f0, t0;
    logic [3:0] ctl;
    logic [0:0] row;
    logic [3:0] exp_ctl [4] = '{CTL_ADDR, CTL_REF, CTL_ADDR, CTL_REF};
    logic [0:0] exp_row [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_outputs", {lcd_enable, mode, reg_sel, DB_sel, data_sel, frame_done, timeout_err}, RST_OUTS);
    checkOutput("reset_row", row_addr, 0);
    checkOutput("reset_err_cnt", err_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // First frame answered 3 cycles after every issue.
    waitEnable(t, ctl, row);
    checkOutput("init_ctl", ctl, CTL_INIT);
    applyStimulus(t + 3);
    tr = 0;
    for (int i = 0; i < 4; i++) begin
      waitEnable(t, ctl, row);
      checkOutput($sformatf("op%0d_ctl", i), ctl, exp_ctl[i]);
      checkOutput($sformatf("op%0d_row", i), row, exp_row[i]);
      tr = t;
      applyStimulus(t + 3);
    end
    waitEnable(ta, ctl, row);
    #1;
    checkOutput("gap_addr_cycle", ta, tr + 20);
    checkOutput("gap_addr_ctl", ctl, CTL_ADDR);
    checkOutput("gap_addr_row", row, 0);
    checkOutput("frame_done_count", fd_cnt, 1);
    checkOutput("frame_done_cycle", fd_last, tr + 4);
    checkOutput("enable_count", en_cnt, 6);
    checkOutput("no_timeout_yet", te_cnt, 0);

    // Withhold lcd_finish in ADDR_WAIT.
    waitEnable(ti, ctl, row);
    #1;
    checkOutput("timeout_cycle", te_last, ta + 1001);
    checkOutput("timeout_count", te_cnt, 1);
    checkOutput("err_cnt_one", err_cnt, 1);
    checkOutput("recover_cycle", ti, ta + 1001);
    checkOutput("recover_ctl", ctl, CTL_INIT);
    checkOutput("recover_row", row, 0);

    // lcd_finish on the final allowed wait cycle.
    applyStimulus(ti + 1000);
    waitEnable(t, ctl, row);
    #1;
    checkOutput("late_finish_cycle", t, ti + 1001);
    checkOutput("late_finish_ctl", ctl, CTL_ADDR);
    checkOutput("late_finish_no_err", te_cnt, 1);
    checkOutput("late_finish_err_cnt", err_cnt, 1);

    // Freeze raised mid-frame is ignored until the gap, then holds it.
    applyStimulus(t + 3);
    waitEnable(t, ctl, row);
    applyStimulus(t + 3);
    freeze = 1'b1;
    waitEnable(t, ctl, row);
    checkOutput("freeze_addr1_row", row, 1);
    applyStimulus(t + 3);
    waitEnable(tr, ctl, row);
    checkOutput("freeze_ref1_ctl", ctl, CTL_REF);
    applyStimulus(tr + 3);
    #1 e0 = en_cnt;
    while (cyc < tr + 53) @(negedge clk);
    #1;
    checkOutput("freeze_no_enable", en_cnt, e0);
    checkOutput("freeze_frame_done", fd_cnt, 2);
    @(posedge clk);
    #1 freeze = 1'b0;
    waitEnable(tf, ctl, row);
    checkOutput("unfreeze_cycle", tf, tr + 55);
    checkOutput("unfreeze_ctl", ctl, CTL_ADDR);
    checkOutput("unfreeze_row", row, 0);

    // Reset during REF_WAIT of row 1.
    applyStimulus(tf + 3);
    for (int i = 0; i < 2; i++) begin
      waitEnable(t, ctl, row);
      applyStimulus(t + 3);
    end
    waitEnable(t, ctl, row);
    checkOutput("pre_reset_row", row, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrun_reset_outputs", {lcd_enable, mode, reg_sel, DB_sel, data_sel, frame_done, timeout_err}, RST_OUTS);
    checkOutput("midrun_reset_row", row_addr, 0);
    checkOutput("midrun_reset_err_cnt", err_cnt, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    waitEnable(t, ctl, row);
    checkOutput("restart_ctl", ctl, CTL_INIT);
    checkOutput("restart_row", row, 0);

    // Small instance: back-to-back timeouts saturate err_cnt.
    @(posedge clk);
    #1 s_rst = 1'b0;
    repeat (930) @(negedge clk);
    #1;
    checkOutput("sat_timeouts_ge_300", s_te_cnt >= 300, 1);
    checkOutput("sat_err_cnt", s_err_cnt, 255);

    // Small instance: every REF completion ends a frame, freeze has no effect.
    s_finish = 1'b1;
    s_freeze = 1'b1;
    repeat (8) @(negedge clk);
    #1 f0 = s_fd_cnt;
    t0 = s_te_cnt;
    repeat (40) @(negedge clk);
    #1;
    checkOutput("one_row_frames", s_fd_cnt - f0, 10);
    checkOutput("one_row_no_timeout", s_te_cnt, t0);
    checkOutput("one_row_err_cnt", s_err_cnt, 255);
    checkOutput("one_row_addr_zero", s_row_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
